// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    // Dark values for the active-low outputs.
    localparam logic [6:0] BLANK_SEG = 7'h7F;
    localparam logic [7:0] BLANK_AN  = 8'hFF;

    typedef enum logic {
        StBlank = 1'b0,
        StDrive = 1'b1
    } scan_state_e;

    // Active-low hex patterns, bit0=a .. bit6=g. The leftmost entry is index 15 (F).
    localparam logic [15:0][6:0] HEX_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Bit k is set when nibbles k..NUM_DIGITS-1 of v are all zero.
    function automatic logic [NUM_DIGITS-1:0] zero_above(input logic [4*NUM_DIGITS-1:0] v);
        logic [NUM_DIGITS-1:0] z;
        logic                  run;
        run = 1'b1;
        z   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run  = run & (v[4*k +: 4] == 4'h0);
            z[k] = run;
        end
        return z;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    // Plain table lookup; all 16 codes are legal.
    always_comb begin
        seg_n_o = HEX_LUT[nibble_i];
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver. A prescaler paces digit slots, each slot
// starts with a dark (anti-ghost) interval, and the displayed value is taken from a shadow
// register that only reloads at frame boundaries so mid-frame updates never tear.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        enable,
    input  logic        lz_blank,
    input  logic [7:0]  dp_mask,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic        frame_start
);

    localparam int unsigned     CntW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
    localparam logic [2:0]      IdxLast   = 3'(NUM_DIGITS - 1);

    // Scan state
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     shadow_q, shadow_d;
    scan_state_e     state_q, state_d;
    logic [CntW-1:0] bcnt_q, bcnt_d;

    // Registered outputs
    logic [7:0] an_n_q, an_n_d;
    logic [6:0] seg_n_q, seg_n_d;
    logic       dp_n_q, dp_n_d;
    logic       frame_start_q, frame_start_d;

    logic                  tick;
    logic                  frame_wrap;
    logic [3:0]            cur_nibble;
    logic [6:0]            dec_seg_n;
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  lz_hide;

    assign tick       = (cnt_q == CntLast);
    assign frame_wrap = tick && (idx_q == IdxLast);
    assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];
    assign zero_from  = zero_above(shadow_q);
    // Digit 0 always shows, so a value of zero still displays a single 0.
    assign lz_hide    = lz_blank && (idx_q != 3'd0) && zero_from[idx_q];

    hex7seg_decode u_decode (
        .nibble_i (cur_nibble),
        .seg_n_o  (dec_seg_n)
    );

    // Prescaler, digit index, shadow capture and blank/drive sequencing
    always_comb begin
        cnt_d         = tick ? '0 : cnt_q + 1'b1;
        idx_d         = tick ? idx_q + 3'd1 : idx_q;
        shadow_d      = frame_wrap ? value : shadow_q;
        frame_start_d = frame_wrap;
        state_d       = state_q;
        bcnt_d        = bcnt_q;

        if (tick) begin
            // Every slot boundary restarts the dark interval regardless of state.
            state_d = StBlank;
            bcnt_d  = '0;
        end else begin
            unique case (state_q)
                StBlank: begin
                    if (bcnt_q == BlankLast) begin
                        state_d = StDrive;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                StDrive: begin
                    state_d = StDrive;
                end
                default: begin
                    state_d = StBlank;
                    bcnt_d  = '0;
                end
            endcase
        end
    end

    // Output pattern for the current state, registered below for one cycle of latency
    always_comb begin
        an_n_d  = BLANK_AN;
        seg_n_d = BLANK_SEG;
        dp_n_d  = 1'b1;
        if (enable && (state_q == StDrive) && !lz_hide) begin
            an_n_d  = ~(8'b1 << idx_q);
            seg_n_d = dec_seg_n;
            dp_n_d  = ~dp_mask[idx_q];
        end
    end

    // All state and output registers; reset is asynchronous
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shadow_q      <= 32'h0;
            state_q       <= StBlank;
            bcnt_q        <= '0;
            an_n_q        <= BLANK_AN;
            seg_n_q       <= BLANK_SEG;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an_n        = an_n_q;
    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver with a cycle-count based reference model.
module tb_seven_seg_scan_driver;

    localparam int unsigned SD    = 8;
    localparam int unsigned BC    = 2;
    localparam int unsigned FRAME = SD * 8;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] value    = 32'h0;
    logic        enable   = 1'b0;
    logic        lz_blank = 1'b0;
    logic [7:0]  dp_mask  = 8'h00;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    seven_seg_scan_driver #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .enable      (enable),
        .lz_blank    (lz_blank),
        .dp_mask     (dp_mask),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Expected outputs, valid between edges.
    logic [7:0]  exp_an  = 8'hFF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp  = 1'b1;
    logic        exp_fs  = 1'b0;
    int unsigned cyc     = 0;
    logic [31:0] m_shadow = 32'h0;

    // Segment sets as lit segments (gfedcba, active-high), inverted for the pins.
    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] lit;
        case (n)
            4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    // Reference: cycle number since reset gives slot position and digit directly.
    initial begin : ref_model
        int unsigned pos;
        int unsigned dig;
        logic [31:0] upper;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                cyc = 0; m_shadow = 32'h0;
                exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
            end else begin
                pos   = cyc % SD;
                dig   = (cyc / SD) % 8;
                upper = m_shadow >> (4 * dig);
                if (enable && pos >= BC && !(lz_blank && dig != 0 && upper == 32'h0)) begin
                    exp_an      = 8'hFF;
                    exp_an[dig] = 1'b0;
                    exp_seg     = ref_seg(upper[3:0]);
                    exp_dp      = ~dp_mask[dig];
                end else begin
                    exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
                end
                exp_fs = (pos == SD - 1) && (dig == 7);
                if (exp_fs) m_shadow = value;
                cyc++;
            end
        end
    end

    task automatic test_reset();
        int drive_cnt;
        value = 32'h12345678; enable = 1'b1; lz_blank = 1'b0; dp_mask = 8'h00;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({an_n, seg_n, dp_n, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h/%h/%b/%b want ff/7f/1/0", an_n, seg_n, dp_n,
                     frame_start);
        end
        reset = 1'b0;
        drive_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL first_frame_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n, seg_n,
                         dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (an_n !== 8'hFF) begin
                drive_cnt++;
                n_tests++;
                if (seg_n !== 7'h40) begin
                    n_fail++;
                    $display("FAIL first_frame_zero: got seg_n=%h want 40", seg_n);
                end
            end
        end
        n_tests++;
        if (drive_cnt != 48) begin
            n_fail++;
            $display("FAIL first_frame_drive_count: got %0d want 48", drive_cnt);
        end
    endtask

    task automatic test_second_frame();
        int drive_cnt;
        drive_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL second_frame_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n,
                         seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (an_n !== 8'hFF) drive_cnt++;
            if (an_n === 8'hFE) begin
                n_tests++;
                if (seg_n !== 7'h00) begin
                    n_fail++;
                    $display("FAIL digit0_eight: got seg_n=%h want 00", seg_n);
                end
            end
            if (an_n === 8'h7F) begin
                n_tests++;
                if (seg_n !== 7'h79) begin
                    n_fail++;
                    $display("FAIL digit7_one: got seg_n=%h want 79", seg_n);
                end
            end
        end
        n_tests++;
        if (drive_cnt != 48) begin
            n_fail++;
            $display("FAIL second_frame_drive_count: got %0d want 48", drive_cnt);
        end
    endtask

    task automatic test_dp();
        dp_mask = 8'h81;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL dp_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n, seg_n, dp_n,
                         frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            n_tests++;
            if (dp_n !== !((an_n === 8'hFE) || (an_n === 8'h7F))) begin
                n_fail++;
                $display("FAIL dp_digits: got dp_n=%b with an_n=%h", dp_n, an_n);
            end
        end
        dp_mask = 8'h00;
    endtask

    task automatic test_lz();
        bit found;
        int d0, d1;
        value = 32'h0000_00A0; lz_blank = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL lz_wait_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n, seg_n,
                         dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            found = frame_start;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL lz_frame_start_timeout: got none want pulse");
        end
        d0 = 0; d1 = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL lz_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n, seg_n, dp_n,
                         frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            n_tests++;
            if (an_n[7:2] !== 6'h3F) begin
                n_fail++;
                $display("FAIL lz_hidden_digits: got an_n=%h want bits 7..2 high", an_n);
            end
            if (an_n === 8'hFE) begin
                d0++;
                n_tests++;
                if (seg_n !== 7'h40) begin
                    n_fail++;
                    $display("FAIL lz_digit0: got seg_n=%h want 40", seg_n);
                end
            end
            if (an_n === 8'hFD) begin
                d1++;
                n_tests++;
                if (seg_n !== 7'h08) begin
                    n_fail++;
                    $display("FAIL lz_digit1: got seg_n=%h want 08", seg_n);
                end
            end
        end
        n_tests++;
        if (d0 != 6 || d1 != 6) begin
            n_fail++;
            $display("FAIL lz_drive_counts: got %0d/%0d want 6/6", d0, d1);
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_no_tear();
        int  fs_seen;
        bit  hit;
        value = 32'h11111111;
        fs_seen = 0;
        // Two frame starts: the second guarantees the shadow holds all ones.
        for (int i = 0; i < 3 * FRAME && fs_seen < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL tear_setup_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n, seg_n,
                         dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (frame_start) fs_seen++;
        end
        hit = 1'b0;
        for (int i = 0; i < FRAME && !hit; i++) begin
            @(negedge clk);
            hit = (an_n === 8'hF7);
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL tear_digit3_timeout: got an_n=%h want f7", an_n);
        end
        value = 32'h22222222;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL tear_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n, seg_n, dp_n,
                         frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (an_n !== 8'hFF) begin
                n_tests++;
                if (seg_n !== 7'h79) begin
                    n_fail++;
                    $display("FAIL tear_old_value: got seg_n=%h an_n=%h want 79", seg_n, an_n);
                end
            end
            hit = frame_start;
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL tear_frame_start_timeout: got none want pulse");
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (an_n !== 8'hFF) begin
                n_tests++;
                if (seg_n !== 7'h24) begin
                    n_fail++;
                    $display("FAIL tear_new_value: got seg_n=%h an_n=%h want 24", seg_n, an_n);
                end
            end
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (an_n !== 8'hFF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
                n_fail++;
                $display("FAIL disabled_dark: got %h/%h/%b want ff/7f/1", an_n, seg_n, dp_n);
            end
            n_tests++;
            if (frame_start !== exp_fs) begin
                n_fail++;
                $display("FAIL disabled_frame_start: got %b want %b", frame_start, exp_fs);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL reenable_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n, seg_n,
                         dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL random_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n, seg_n,
                         dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if ($urandom_range(7) == 0) begin
                // Bias towards leading zeros so blanking gets exercised.
                value = $urandom() >> (4 * $urandom_range(7));
            end
            if ($urandom_range(15) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(7) == 0) dp_mask = 8'($urandom());
            if ($urandom_range(31) == 0) enable = ~enable;
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        value = 32'h87654321; lz_blank = 1'b0;
        for (int i = 0; i < FRAME && !hit; i++) begin
            @(negedge clk);
            hit = (an_n !== 8'hFF);
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_drive_timeout: got an_n=%h want driven", an_n);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({an_n, seg_n, dp_n, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%h/%b/%b want ff/7f/1/0", an_n, seg_n, dp_n,
                     frame_start);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2 * SD; i++) begin
            @(negedge clk);
            n_tests++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL reset_restart_model: got %h/%h/%b/%b want %h/%h/%b/%b", an_n,
                         seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (i < BC) begin
                n_tests++;
                if (an_n !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL reset_restart_blank: got an_n=%h want ff", an_n);
                end
            end else if (i < SD) begin
                n_tests++;
                if (an_n !== 8'hFE || seg_n !== 7'h40) begin
                    n_fail++;
                    $display("FAIL reset_restart_digit0: got %h/%h want fe/40", an_n, seg_n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_second_frame();
        test_dp();
        test_lz();
        test_no_tear();
        test_enable();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
